// File: rtl/signed_diff_pipe.sv
// Recovers the unknown addend of a signed add (b = sum - a) through a two-stage
// valid/ready pipeline, saturating b to its width and counting saturated deliveries.
module signed_diff_pipe #(
    parameter int aWidth   = 8,
    parameter int bWidth   = 9,
    parameter int sumWidth = 10,
    parameter int cntWidth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [sumWidth-1:0] sum,
    input  logic signed [aWidth-1:0]   a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [bWidth-1:0]   b,
    output logic                       ovf,
    output logic [cntWidth-1:0]        ovf_count
);

    // DW holds any sum - a without wrapping; CW also holds the bWidth-wide limits.
    localparam int DW = ((sumWidth > aWidth) ? sumWidth : aWidth) + 1;
    localparam int CW = ((DW > bWidth) ? DW : bWidth) + 1;

    localparam logic signed [CW-1:0] B_MAX = $signed({{(CW-bWidth+1){1'b0}}, {(bWidth-1){1'b1}}});
    localparam logic signed [CW-1:0] B_MIN = $signed({{(CW-bWidth+1){1'b1}}, {(bWidth-1){1'b0}}});

    logic                    s1_valid;
    logic                    s2_valid;
    logic signed [DW-1:0]    diff_q;
    logic signed [DW-1:0]    sum_x;
    logic signed [DW-1:0]    a_x;
    logic signed [CW-1:0]    diff_w;
    logic signed [bWidth-1:0] b_d;
    logic                    ovf_d;
    logic                    s1_load;
    logic                    s2_load;
    logic                    out_fire;

    assign sum_x  = {{(DW-sumWidth){sum[sumWidth-1]}}, sum};
    assign a_x    = {{(DW-aWidth){a[aWidth-1]}}, a};
    assign diff_w = {{(CW-DW){diff_q[DW-1]}}, diff_q};

    // NOTE: in_ready depends only on pipeline state and out_ready, never on in_valid,
    // so an upstream that waits for ready before raising valid cannot form a loop.
    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_fire  = s2_valid & out_ready;
    assign out_valid = s2_valid;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the if/else leaves it unassigned and no latch is inferred.
    always_comb begin
        b_d   = diff_w[bWidth-1:0];
        ovf_d = 1'b0;
        if (diff_w > B_MAX) begin
            b_d   = B_MAX[bWidth-1:0];
            ovf_d = 1'b1;
        end else if (diff_w < B_MIN) begin
            b_d   = B_MIN[bWidth-1:0];
            ovf_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values and stage order inside the block does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            diff_q   <= '0;
        end else begin
            s1_valid <= s1_load | (s1_valid & ~s2_load);
            if (s1_load) begin
                diff_q <= sum_x - a_x;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            b        <= '0;
            ovf      <= 1'b0;
        end else begin
            s2_valid <= s2_load | (s2_valid & ~out_fire);
            if (s2_load) begin
                b   <= b_d;
                ovf <= ovf_d;
            end
        end
    end

    // Counted at delivery so a stalled saturated result is counted exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (out_fire && ovf && !(&ovf_count)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_signed_diff_pipe.sv
// Scoreboard bench for signed_diff_pipe: expected b/ovf are queued at input accept
// and compared at output transfer; a second instance exercises counter saturation.
module tb_signed_diff_pipe;

    localparam int A_W  = 8;
    localparam int B_W  = 9;
    localparam int S_W  = 10;
    localparam int C_W  = 16;
    localparam int BMAX = (1 << (B_W - 1)) - 1;
    localparam int BMIN = -(1 << (B_W - 1));
    localparam int CNT_TOP = (1 << C_W) - 1;

    typedef struct {
        int b;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  in_valid;
    logic                  in_ready;
    logic signed [S_W-1:0] sum;
    logic signed [A_W-1:0] a;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [B_W-1:0] b;
    logic                  ovf;
    logic [C_W-1:0]        ovf_count;

    logic                  c_in_valid;
    logic                  c_in_ready;
    logic signed [S_W-1:0] c_sum;
    logic signed [A_W-1:0] c_a;
    logic                  c_out_valid;
    logic                  c_out_ready;
    logic signed [B_W-1:0] c_b;
    logic                  c_ovf;
    logic [1:0]            c_ovf_count;

    signed_diff_pipe #(.aWidth(A_W), .bWidth(B_W), .sumWidth(S_W), .cntWidth(C_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .b(b), .ovf(ovf), .ovf_count(ovf_count)
    );

    signed_diff_pipe #(.aWidth(A_W), .bWidth(B_W), .sumWidth(S_W), .cntWidth(2)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .sum(c_sum), .a(c_a),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .b(c_b), .ovf(c_ovf),
        .ovf_count(c_ovf_count)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    bit   last_acc;
    bit   last_del;

    int   bs_s[4] = '{2, 105, 100, 142};
    int   bs_a[4] = '{1, 100, 89, 127};
    int   bp_s[4] = '{10, 20, -30, 0};
    int   bp_a[4] = '{3, -5, 7, 100};
    int   k, ndel, steps, nd;
    bit   d;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int s, input int av);
        exp_t e;
        int   diff;
        diff  = s - av;
        e.b   = diff;
        e.ovf = 0;
        if (diff > BMAX) begin
            e.b   = BMAX;
            e.ovf = 1;
        end else if (diff < BMIN) begin
            e.b   = BMIN;
            e.ovf = 1;
        end
        return e;
    endfunction

    task automatic drive(input int s, input int av);
        in_valid = 1'b1;
        sum      = S_W'(s);
        a        = A_W'(av);
    endtask

    // Called just after a falling edge with inputs set; returns just after the next one.
    task automatic step();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        last_del = out_valid && out_ready;
        if (last_del) begin
            check("sb_nonempty", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("b", b, e.b);
                check("ovf", ovf, e.ovf);
                if (e.ovf != 0 && exp_cnt < CNT_TOP) exp_cnt++;
            end
        end
        if (last_acc) sb.push_back(model(int'(sum), int'(a)));
        @(posedge clk);
        #1;
        if (last_del) check("ovf_count", ovf_count, exp_cnt);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_done", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        sum         = '0;
        a           = '0;
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        c_sum       = '0;
        c_a         = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_b", b, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ovf_count", ovf_count, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Basic flow, two-cycle latency
        for (int i = 0; i < 4; i++) begin
            drive(bs_s[i], bs_a[i]);
            step();
            if (i == 0) check("lat_c1_valid", out_valid, 0);
            if (i == 1) begin
                check("lat_c2_valid", out_valid, 1);
                check("lat_c2_b", b, 1);
            end
        end
        drain();
        check("basic_cnt", ovf_count, 0);

        // Saturation at both limits and a plain negative case
        drive(511, -128); step();
        drive(-512, 127); step();
        drive(-1, -1);    step();
        drain();
        check("sat_cnt", ovf_count, 2);

        // Backpressure: only two items fit while the output is stalled
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (k < 4) drive(bp_s[k], bp_a[k]);
            else in_valid = 1'b0;
            step();
            if (last_acc) k++;
        end
        check("bp_accepted", k, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_b", b, 7);
        out_ready = 1'b1;
        ndel  = 0;
        steps = 0;
        while (ndel < 4 && steps < 20) begin
            if (k < 4) drive(bp_s[k], bp_a[k]);
            else in_valid = 1'b0;
            step();
            if (last_acc) k++;
            if (last_del) ndel++;
            steps++;
        end
        check("bp_delivered", ndel, 4);
        check("bp_nogap", steps, 4);
        check("bp_sb_empty", sb.size(), 0);

        // Simultaneous pop/move/accept with toggling out_ready
        for (int c = 0; c < 12; c++) begin
            out_ready = (c % 2 == 0);
            drive(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
            step();
            if (c >= 2) check("simul_pair", last_acc, last_del);
        end
        drain();
        check("simul_cnt", ovf_count, 2);

        // Mid-flight asynchronous reset
        drive(400, -100); step();
        drain();
        check("pre_rst_cnt", ovf_count, 3);
        out_ready = 1'b0;
        drive(5, 1); step();
        drive(6, 1); step();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_cnt", ovf_count, 0);
        check("async_rst_b", b, 0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        drive(4, 2);
        step();
        check("post_rst_lat1", out_valid, 0);
        in_valid = 1'b0;
        step();
        check("post_rst_lat2", out_valid, 1);
        check("post_rst_b", b, 2);
        drain();

        // Counter saturation on the 2-bit instance
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            c_in_valid = (c < 5);
            c_sum      = S_W'(511);
            c_a        = A_W'(-128);
            #1;
            d = c_out_valid && c_out_ready;
            if (d) check("c_ovf", c_ovf, 1);
            @(posedge clk);
            #1;
            if (d) begin
                nd++;
                check("c_cnt", c_ovf_count, (nd > 3) ? 3 : nd);
            end
            @(negedge clk);
        end
        check("c_delivered", nd, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/signed_diff_pipe.md
Name: signed_diff_pipe

Overview:
- Inverse of the signed adder `testImport`: takes a sum and one addend, returns the other addend (b = sum - a).
- Sits on the result-return side of the adder datapath; the bench also uses it as the reference model that recovers operands for self-checking.
- Two-stage registered pipeline with valid/ready handshakes on both sides, saturation to the output width, and a saturating overflow event counter.

Parameters:
- aWidth, 8, width of signed addend input a
- bWidth, 9, width of signed recovered-addend output b
- sumWidth, 10, width of signed sum input
- cntWidth, 16, width of overflow event counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  sum/a valid
- in_ready  output  1  block can accept sum/a this cycle
- sum  input  sumWidth  signed sum operand
- a  input  aWidth  signed known addend
- out_valid  output  1  b/ovf valid
- out_ready  input  1  downstream accepts b/ovf
- b  output  bWidth  signed recovered addend, saturated
- ovf  output  1  b was saturated for this result
- ovf_count  output  cntWidth  number of saturated results delivered, sticks at all-ones

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset, asserted at any time including mid-operation:
  - s1_valid=0, s2_valid=0, out_valid=0, b=0, ovf=0, ovf_count=0, in_ready=1 on the first cycle after release.
  - In-flight data is dropped.
- Handshake: a transfer happens on a rising edge where valid&ready are both high.
- Stage 1 (s1):
  - Registers diff = sext(sum) - sext(a).
  - Both operands are sign-extended to DW = max(sumWidth,aWidth)+1 bits, so diff never wraps.
- Stage 2 (s2):
  - Compares diff against MAX = 2^(bWidth-1)-1 and MIN = -2^(bWidth-1).
  - diff>MAX: b=MAX, ovf=1. diff<MIN: b=MIN, ovf=1. Otherwise b=diff[bWidth-1:0], ovf=0.
  - Drives b/ovf/out_valid directly from registers.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | out_ready)
  - s1_load = in_valid & in_ready
  - in_ready = !s1_valid | s2_load (combinational from state and out_ready only; never from in_valid).
- s1_valid next value: s1_load ? 1 : (s2_load ? 0 : s1_valid).
- s2_valid next value: s2_load ? 1 : ((out_valid & out_ready) ? 0 : s2_valid).
- Latency: 2 cycles from accepted input to out_valid when there is no backpressure. Throughput: 1 result per cycle.
- Stall: while out_valid & !out_ready, b/ovf/out_valid hold stable. s1 keeps at most one further item, then in_ready=0.
- Simultaneous events: output pop, s1->s2 move and new input accept can all happen on the same edge with no bubble.
- Ordering: results leave in acceptance order; no item is dropped or duplicated.
- ovf_count:
  - Increments by 1 on each output transfer with ovf=1 (counts at delivery, not at compute).
  - Saturates at 2^cntWidth-1.
  - Does not change on stalled cycles.
- Output data while out_valid=0 is don't-care; the RTL holds the last value.

Test Plan:
- Basic, out_ready=1:
  - Accept (sum=2, a=1), (105, 100), (100, 89), (142, 127) on consecutive cycles.
  - Expect b=1, 5, 11, 15 on cycles 2-5, all ovf=0, ovf_count=0.
- Saturation:
  - (sum=511, a=-128): diff 639 -> b=255, ovf=1.
  - (sum=-512, a=127): diff -639 -> b=-256, ovf=1.
  - (sum=-1, a=-1): b=0, ovf=0.
  - Expect ovf_count=2 after all three are delivered.
- Backpressure:
  - Hold out_ready=0 and offer 4 back-to-back inputs.
  - Only 2 are accepted; in_ready=0 from then on; b holds the first result stable.
  - Release out_ready: all 4 results come out in order with no gap.
- Simultaneous:
  - Keep in_valid=1, and toggle out_ready 1,0,1,0.
  - Every output transfer coincides with an input accept once the pipe is full.
  - A scoreboard confirms no loss and no duplication.
- Reset mid-flight:
  - Assert rst asynchronously (between clock edges) with 2 items in flight and ovf_count=3.
  - out_valid falls immediately; ovf_count=0.
  - After release, in_ready=1 and a new (sum=4, a=2) yields b=2 two cycles later.
- Counter saturation (cntWidth=2):
  - Deliver 5 overflowing results.
  - ovf_count sequence 1, 2, 3, 3, 3.
